qif_syn_scheduler: RTL

QIF_SYN_SCHEDULER -- requirements
Module: qif_syn_scheduler

---
 rtl/qif_syn_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/qif_syn_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qif_syn_scheduler: round-robin synaptic scheduler and spike/refractory      |
// | controller wrapped around a QIF_8B neuron core.  Rev 1.0                    |
// +----------------------------------------------------------------------------+
module qif_syn_scheduler #(
  parameter logic [7:0] V_TH    = 8'd200,
  parameter int         REFRACT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] weight,
  output logic [3:0]  ack,
  output logic [7:0]  i_syn,
  input  logic [7:0]  v_mem,
  output logic        core_rst_n,
  output logic        spike,
  output logic [7:0]  spike_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  localparam logic [7:0] C_REFR_INIT = 8'(REFRACT - 1);

  state_t      state_q, state_d;
  logic [1:0]  p_q, p_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [3:0]  ack_q, ack_d;
  logic [7:0]  i_syn_q, i_syn_d;
  logic        spike_q, spike_d;
  logic [7:0]  spike_cnt_q, spike_cnt_d;
  logic        busy_q, busy_d;
  logic        core_rst_n_q, core_rst_n_d;

  logic        spike_det;
  logic        grant_valid;
  logic [1:0]  winner;
  logic [1:0]  cand;

  assign spike_det = (v_mem >= V_TH);

  // Round-robin search starting at the pointer, wrapping modulo 4.
  always_comb begin
    grant_valid = 1'b0;
    winner      = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = p_q + 2'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        winner      = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    rcnt_d       = rcnt_q;
    ack_d        = 4'd0;
    i_syn_d      = 8'd0;
    spike_d      = 1'b0;
    spike_cnt_d  = spike_cnt_q;
    busy_d       = 1'b0;
    core_rst_n_d = 1'b1;
    case (state_q)
      ST_IDLE, ST_DRIVE: begin
        if (spike_det) begin
          // A spike outranks any pending request; no grant on this edge.
          state_d      = ST_REFRACT;
          spike_d      = 1'b1;
          spike_cnt_d  = (spike_cnt_q == 8'hFF) ? spike_cnt_q : spike_cnt_q + 8'd1;
          rcnt_d       = C_REFR_INIT;
          busy_d       = 1'b1;
          core_rst_n_d = 1'b0;
        end else if (state_q == ST_IDLE && grant_valid) begin
          state_d = ST_DRIVE;
          ack_d   = 4'b0001 << winner;
          i_syn_d = weight[{winner, 3'b000} +: 8];
          p_d     = winner + 2'd1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REFRACT: begin
        if (rcnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          rcnt_d       = rcnt_q - 8'd1;
          busy_d       = 1'b1;
          core_rst_n_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      p_q          <= 2'd0;
      rcnt_q       <= 8'd0;
      ack_q        <= 4'd0;
      i_syn_q      <= 8'd0;
      spike_q      <= 1'b0;
      spike_cnt_q  <= 8'd0;
      busy_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      rcnt_q       <= rcnt_d;
      ack_q        <= ack_d;
      i_syn_q      <= i_syn_d;
      spike_q      <= spike_d;
      spike_cnt_q  <= spike_cnt_d;
      busy_q       <= busy_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign ack        = ack_q;
  assign i_syn      = i_syn_q;
  assign spike      = spike_q;
  assign spike_cnt  = spike_cnt_q;
  assign busy       = busy_q;
  assign core_rst_n = core_rst_n_q;

endmodule
`default_nettype wire
